walk_ctrl: RTL and testbench

Run-control and step scheduler for the walking-circle display path. Sits between the user push-buttons (already debounced and synchronised to single-cycle pulses) and the walking-circle engine. Replaces the free-running prescaler counter as the source of the engine's step pulse. It adds start/stop, single-step, direction reversal and an 8-level speed setting.

---
 rtl/walk_ctrl.sv | 96 +++++++++
 tb/tb_walk_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/walk_ctrl.sv
// Run-control and step scheduler for the walking-circle engine: start/stop,
// single-step, direction toggle and an 8-level step rate.
module walk_ctrl #(
  parameter int BASE_PERIOD = 128,
  parameter int CNT_WIDTH   = $clog2(BASE_PERIOD)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic       step_i,
  input  logic       dir_i,
  input  logic       faster_i,
  input  logic       slower_i,
  output logic       step_o,
  output logic       dir_o,
  output logic       running_o,
  output logic [2:0] speed_o,
  output logic [1:0] state_o
);

  // All push-button inputs are single-cycle pulses with no ready/back-pressure:
  // a pulse is acted on at the rising edge where it is high, or dropped if the
  // current state ignores it. step_o is a one-cycle strobe with no handshake.

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    SSTEP   = 2'd2
  } state_t;

  // BASE_PERIOD is a power of two, so (BASE >> s) - 1 == (BASE - 1) >> s.
  localparam logic [CNT_WIDTH-1:0] BASE_M1 = CNT_WIDTH'(BASE_PERIOD - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] period_m1;
  logic                 speed_up;
  logic                 speed_dn;
  logic                 cnt_wrap;

  always_comb begin
    period_m1 = BASE_M1 >> speed_o;
    speed_up  = faster_i && !slower_i && (speed_o != 3'd7);
    speed_dn  = slower_i && !faster_i && (speed_o != 3'd0);
    cnt_wrap  = (cnt == period_m1);
    step_o    = (state == SSTEP) || ((state == RUNNING) && cnt_wrap);
  end

  assign running_o = (state == RUNNING);
  assign state_o   = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= STOPPED;
      cnt     <= '0;
      speed_o <= 3'd0;
      dir_o   <= 1'b0;
    end else begin
      // The engine samples dir_o on the same edge, so a coincident step still
      // uses the pre-toggle direction.
      if (dir_i) dir_o <= ~dir_o;

      if (state != SSTEP) begin
        if (speed_up)      speed_o <= speed_o + 3'd1;
        else if (speed_dn) speed_o <= speed_o - 3'd1;
      end

      case (state)
        STOPPED: begin
          cnt <= '0;
          if (run_i)       state <= RUNNING;
          else if (step_i) state <= SSTEP;
        end
        RUNNING: begin
          if (run_i) begin
            state <= STOPPED;
            cnt   <= '0;
          end else if (speed_up || speed_dn || cnt_wrap) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        SSTEP: begin
          cnt   <= '0;
          state <= STOPPED;
        end
        default: begin
          cnt   <= '0;
          state <= STOPPED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_walk_ctrl.sv
// Directed bench for walk_ctrl: a table of one-cycle vectors plus hand-written
// sequences for step cadence, speed changes, direction and async reset.
module tb_walk_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       run_i = 1'b0;
  logic       step_i = 1'b0;
  logic       dir_i = 1'b0;
  logic       faster_i = 1'b0;
  logic       slower_i = 1'b0;
  logic       step_o;
  logic       dir_o;
  logic       running_o;
  logic [2:0] speed_o;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       run;
    logic       step;
    logic       dir;
    logic       faster;
    logic       slower;
    logic       e_step;
    logic       e_dir;
    logic       e_run;
    logic [2:0] e_speed;
  } vec_t;

  vec_t       vecs [16];
  logic [5:0] exp_q [$];

  walk_ctrl #(.BASE_PERIOD(128)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .step_i(step_i),
    .dir_i(dir_i), .faster_i(faster_i), .slower_i(slower_i),
    .step_o(step_o), .dir_o(dir_o), .running_o(running_o),
    .speed_o(speed_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- driver tasks ----------------
  // Advance one rising edge, then drop every pulse input 1 ns later.
  task automatic cyc();
    @(posedge clk_i);
    #1;
    run_i = 1'b0; step_i = 1'b0; dir_i = 1'b0; faster_i = 1'b0; slower_i = 1'b0;
  endtask

  // Edges advanced (including the first) until step_o is seen; -1 on timeout.
  task automatic wait_step(input int max, output int n);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (step_o !== 1'b1 && k < max);
    n = (step_o === 1'b1) ? k : -1;
  endtask

  task automatic count_steps(input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      cyc();
      if (step_o === 1'b1) c++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int n;
    int c;
    logic [5:0] exp_v;

    //            run   step  dir   fast  slow  e_stp e_dir e_run e_speed
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};

    // Reset held 10 clocks, then 300 idle clocks.
    repeat (10) cyc();
    check("rst_step", step_o, 0);
    check("rst_dir", dir_o, 0);
    check("rst_running", running_o, 0);
    check("rst_speed", speed_o, 0);
    rst_i = 1'b0;
    count_steps(300, c);
    check("idle_steps", c, 0);
    check("idle_outputs", {step_o, dir_o, running_o, speed_o}, 0);

    // Table-driven single-cycle vectors from the reset state.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({vecs[i].e_step, vecs[i].e_dir, vecs[i].e_run, vecs[i].e_speed});
      run_i = vecs[i].run; step_i = vecs[i].step; dir_i = vecs[i].dir;
      faster_i = vecs[i].faster; slower_i = vecs[i].slower;
      cyc();
      exp_v = exp_q.pop_front();
      check($sformatf("vec%0d", i), {step_o, dir_o, running_o, speed_o}, exp_v);
    end

    // Periodic run at speed 0.
    rst_i = 1'b1;
    repeat (2) cyc();
    rst_i = 1'b0;
    run_i = 1'b1;
    wait_step(200, n);
    check("first_step_p128", n, 128);
    wait_step(200, n);
    check("gap_p128_a", n, 128);
    wait_step(200, n);
    check("gap_p128_b", n, 128);

    // Three faster pulses -> speed 3, period 16 from the last pulse.
    faster_i = 1'b1; cyc();
    faster_i = 1'b1; cyc();
    faster_i = 1'b1;
    wait_step(200, n);
    check("speed3", speed_o, 3);
    check("first_step_p16", n, 16);
    wait_step(200, n);
    check("gap_p16", n, 16);

    // Four more plus two saturated -> speed 7, step every cycle.
    repeat (6) begin
      faster_i = 1'b1;
      cyc();
    end
    check("speed7_sat", speed_o, 7);
    check("speed7_step_now", step_o, 1);
    count_steps(10, c);
    check("speed7_every_cycle", c, 10);

    // Down to speed 2, then slower mid-period clears cnt.
    repeat (4) begin
      slower_i = 1'b1;
      cyc();
    end
    slower_i = 1'b1;
    wait_step(200, n);
    check("speed2", speed_o, 2);
    check("first_step_p32", n, 32);
    repeat (10) cyc();
    slower_i = 1'b1;
    wait_step(200, n);
    check("slower_speed1", speed_o, 1);
    check("slower_restart_p64", n, 64);

    // faster+slower together: no change, cadence undisturbed.
    repeat (20) cyc();
    faster_i = 1'b1; slower_i = 1'b1;
    wait_step(200, n);
    check("both_speed", speed_o, 1);
    check("both_cadence", n, 44);

    // step_i while RUNNING adds nothing.
    step_i = 1'b1;
    wait_step(200, n);
    check("step_in_run", n, 64);

    // dir_i coincident with a step: step carries the old direction.
    dir_i = 1'b1;
    check("coinc_step_old_dir", {step_o, dir_o}, 2'b10);
    cyc();
    check("dir_after_toggle", dir_o, 1);
    wait_step(200, n);
    check("gap_after_dir", n, 63);

    // run_i on a step cycle: step appears, then none.
    run_i = 1'b1;
    check("stop_step_visible", step_o, 1);
    cyc();
    check("stopped_running", running_o, 0);
    count_steps(200, c);
    check("stopped_no_steps", c, 0);

    // Back-to-back step_i: second pulse lost.
    step_i = 1'b1; cyc();
    check("sstep_first", step_o, 1);
    step_i = 1'b1; cyc();
    check("sstep_second_lost", {step_o, running_o}, 0);
    cyc();
    check("sstep_quiet", step_o, 0);

    // Async reset mid-run at speed 5.
    repeat (4) begin
      faster_i = 1'b1;
      cyc();
    end
    run_i = 1'b1;
    cyc();
    repeat (37) cyc();
    check("pre_rst_state", {dir_o, running_o, speed_o}, {1'b1, 1'b1, 3'd5});
    #3 rst_i = 1'b1;
    #1;
    check("async_rst_running", running_o, 0);
    check("async_rst_speed", speed_o, 0);
    check("async_rst_dir", dir_o, 0);
    check("async_rst_step", step_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    count_steps(50, c);
    check("post_rst_no_steps", c, 0);
    check("post_rst_stopped", {running_o, speed_o}, 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
